uart_bus_master: RTL and testbench

// Serial debug bridge that initiates 16-bit memory-bus cycles on the mem_io addr/din/we/dout bus.
// - Parses command frames from uart_rx bytes, arbitrates with the CPU via bus_req/bus_gnt,

---
 rtl/uart_bus_master.sv | 205 ++++++++++++++++++++
 tb/tb_uart_bus_master.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// UART debug bridge: parses W/R command frames from uart_rx, performs one
// 16-bit bus cycle as a second bus master and replies through uart_tx.
module uart_bus_master #(
  parameter int READ_LAT    = 1,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  output logic        bus_we,
  input  logic [15:0] bus_rdata,
  output logic        busy,
  output logic        err_overrun
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int LW = $clog2(READ_LAT + 1);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] REPLY_ACK = 8'h4B;
  localparam logic [7:0] REPLY_BAD = 8'h3F;

  typedef enum logic [3:0] {
    IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L, REQ, ACCESS, RD_WAIT, TX_SEND, TX_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic            isWrite_q, isWrite_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [7:0]      replyLo_q, replyLo_d;
  logic [7:0]      txByte_q, txByte_d;
  logic            txMore_q, txMore_d;
  logic [LW-1:0]   latCnt_q, latCnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            overrun_q, overrun_d;

  logic inFrame;
  logic tmoHit;
  logic cantAccept;

  assign inFrame    = state_q inside {ADDR_H, ADDR_L, DATA_H, DATA_L};
  assign tmoHit     = inFrame && !rx_valid && (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign cantAccept = state_q inside {REQ, ACCESS, RD_WAIT, TX_SEND, TX_WAIT};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      isWrite_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      replyLo_q <= '0;
      txByte_q  <= '0;
      txMore_q  <= 1'b0;
      latCnt_q  <= '0;
      tmo_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      isWrite_q <= isWrite_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      replyLo_q <= replyLo_d;
      txByte_q  <= txByte_d;
      txMore_q  <= txMore_d;
      latCnt_q  <= latCnt_d;
      tmo_q     <= tmo_d;
      overrun_q <= overrun_d;
    end
  end

  // Inter-byte silence counter; only runs while a frame is partially received.
  always_comb begin
    tmo_d = tmo_q;
    if (rx_valid || !inFrame || tmoHit) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    isWrite_d = isWrite_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    replyLo_d = replyLo_q;
    txByte_d  = txByte_q;
    txMore_d  = txMore_q;
    latCnt_d  = latCnt_q;
    overrun_d = overrun_q | (rx_valid && cantAccept);

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          isWrite_d = (rx_byte == CMD_WRITE);
          if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
            state_d = ADDR_H;
          end else begin
            txByte_d = REPLY_BAD;
            txMore_d = 1'b0;
            state_d  = TX_SEND;
          end
        end
      end
      ADDR_H: begin
        if (rx_valid) begin
          addr_d[15:8] = rx_byte;
          state_d      = ADDR_L;
        end else if (tmoHit) begin
          state_d = IDLE;
        end
      end
      ADDR_L: begin
        if (rx_valid) begin
          addr_d[7:0] = rx_byte;
          state_d     = isWrite_q ? DATA_H : REQ;
        end else if (tmoHit) begin
          state_d = IDLE;
        end
      end
      DATA_H: begin
        if (rx_valid) begin
          wdata_d[15:8] = rx_byte;
          state_d       = DATA_L;
        end else if (tmoHit) begin
          state_d = IDLE;
        end
      end
      DATA_L: begin
        if (rx_valid) begin
          wdata_d[7:0] = rx_byte;
          state_d      = REQ;
        end else if (tmoHit) begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus_gnt) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (isWrite_q) begin
          txByte_d = REPLY_ACK;
          txMore_d = 1'b0;
          state_d  = TX_SEND;
        end else begin
          latCnt_d = '0;
          state_d  = RD_WAIT;
        end
      end
      // High byte goes straight to the transmitter; low byte waits its turn.
      RD_WAIT: begin
        if (latCnt_q == LW'(READ_LAT - 1)) begin
          txByte_d  = bus_rdata[15:8];
          replyLo_d = bus_rdata[7:0];
          txMore_d  = 1'b1;
          state_d   = TX_SEND;
        end else begin
          latCnt_d = latCnt_q + 1'b1;
        end
      end
      TX_SEND: begin
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_done) begin
          if (txMore_q) begin
            txByte_d = replyLo_q;
            txMore_d = 1'b0;
            state_d  = TX_SEND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from the state register so an async reset clears them at once.
  always_comb begin
    bus_req     = state_q inside {REQ, ACCESS, RD_WAIT};
    bus_addr    = (state_q inside {ACCESS, RD_WAIT}) ? addr_q : 16'h0000;
    bus_we      = (state_q == ACCESS) && isWrite_q;
    bus_wdata   = bus_we ? wdata_q : 16'h0000;
    tx_start    = (state_q == TX_SEND);
    tx_byte     = txByte_q;
    busy        = (state_q != IDLE);
    err_overrun = overrun_q;
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Randomized bench for uart_bus_master: frames are fed byte by byte and the
// bus writes, reply bytes and reply latency are compared to a transaction model.
module tb_uart_bus_master;

  localparam int READ_LAT = 1;
  localparam int TIMEOUT  = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_we;
  logic [15:0] bus_rdata = 16'h0000;
  logic        busy;
  logic        err_overrun;

  uart_bus_master #(.READ_LAT(READ_LAT), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_start(tx_start), .tx_done(tx_done),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_rdata(bus_rdata),
    .busy(busy), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flagFail(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got an event, expected none", name);
  endtask

  // Environment: synchronous RAM with one switch register mapped at F004.
  logic [15:0] switchVal = 16'hA5A5;
  logic [15:0] envRam [logic [15:0]];

  function automatic logic [15:0] envRead(input logic [15:0] a);
    if (a == 16'hF004) return switchVal;
    if (envRam.exists(a)) return envRam[a];
    return a ^ 16'h5A3C;
  endfunction

  always @(posedge clk) begin
    if (bus_we) envRam[bus_addr] = bus_wdata;
    bus_rdata <= envRead(bus_addr);
  end

  // Reference model: expected memory contents, reply bytes and bus writes.
  logic [15:0] modelMem [logic [15:0]];
  logic [7:0]  txQ [$];
  logic [31:0] wrQ [$];
  logic [7:0]  txLog [$];
  logic [31:0] wrLog [$];

  function automatic logic [15:0] modelRead(input logic [15:0] a);
    if (a == 16'hF004) return switchVal;
    if (modelMem.exists(a)) return modelMem[a];
    return a ^ 16'h5A3C;
  endfunction

  // Arbiter: grant after gntDelay cycles of request, or always when tied.
  logic gntTie = 1'b1;
  int   gntDelay = 0;
  int   reqCycles = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (gntTie) begin
        bus_gnt   = 1'b1;
        reqCycles = 0;
      end else if (!bus_req) begin
        bus_gnt   = 1'b0;
        reqCycles = 0;
      end else if (reqCycles >= gntDelay) begin
        bus_gnt = 1'b1;
      end else begin
        reqCycles++;
      end
    end
  end

  // UART transmitter stand-in: tx_done txDelay cycles after each tx_start.
  int txDelay = 4;
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start && rst_n) begin
        repeat (txDelay) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  // Per-cycle comparison of the bus and UART outputs against the model.
  int       cyc = 0;
  int       gntCyc = 0;
  bit       gntSeen = 1'b0;
  bit       sawWe = 1'b0;
  bit       txActive = 1'b0;
  logic [7:0]  txHeld = 8'h00;
  logic [31:0] expWr;
  logic [7:0]  expTx;
  always @(negedge clk) begin
    if (!rst_n) begin
      gntSeen  = 1'b0;
      txActive = 1'b0;
    end else begin
      cyc++;
      if (!bus_req) checkOutput("bus_idle_zero", {bus_addr, bus_wdata, bus_we}, 64'd0);
      if (bus_req && bus_gnt && !gntSeen) begin
        gntSeen = 1'b1;
        gntCyc  = cyc;
        sawWe   = 1'b0;
      end
      if (bus_we) begin
        sawWe = 1'b1;
        checkOutput("we_with_req", bus_req, 1);
        wrLog.push_back({bus_addr, bus_wdata});
        if (wrQ.size() == 0) flagFail("unexpected_bus_write");
        else begin
          expWr = wrQ.pop_front();
          checkOutput("bus_write", {bus_addr, bus_wdata}, expWr);
        end
      end
      if (tx_start) begin
        if (gntSeen) checkOutput("reply_latency", cyc - gntCyc, sawWe ? 2 : READ_LAT + 2);
        gntSeen = 1'b0;
        txLog.push_back(tx_byte);
        if (txQ.size() == 0) flagFail("unexpected_tx_start");
        else begin
          expTx = txQ.pop_front();
          checkOutput("tx_byte", tx_byte, expTx);
        end
        txActive = 1'b1;
        txHeld   = tx_byte;
      end else if (txActive) begin
        checkOutput("tx_byte_hold", tx_byte, txHeld);
      end
      if (tx_done) txActive = 1'b0;
    end
  end

  task automatic sendByte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    @(posedge clk);
    #1 rx_byte = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  // kind 0 = write, 1 = read, 2 = unknown command byte data[7:0].
  task automatic applyStimulus(input int kind, input logic [15:0] addr,
                               input logic [15:0] data, input int gap);
    logic [15:0] rd;
    if (kind == 0) begin
      wrQ.push_back({addr, data});
      modelMem[addr] = data;
      txQ.push_back(8'h4B);
      sendByte(8'h57, gap);
      sendByte(addr[15:8], gap);
      sendByte(addr[7:0], gap);
      sendByte(data[15:8], gap);
      sendByte(data[7:0], gap);
    end else if (kind == 1) begin
      rd = modelRead(addr);
      txQ.push_back(rd[15:8]);
      txQ.push_back(rd[7:0]);
      sendByte(8'h52, gap);
      sendByte(addr[15:8], gap);
      sendByte(addr[7:0], gap);
    end else begin
      txQ.push_back(8'h3F);
      sendByte(data[7:0], gap);
    end
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) flagFail({name, "_idle_timeout"});
    checkOutput({name, "_replies_drained"}, txQ.size() + wrQ.size(), 0);
  endtask

  logic [15:0] pool [6] = '{16'h0010, 16'h0100, 16'h1234, 16'h8000, 16'hFFFF, 16'h0000};

  initial begin
    int reqNoGnt;
    int addrEarly;
    int nLog;
    int nWr;
    int n;
    int kind;
    logic [7:0] bad;

    #12;
    checkOutput("reset_outputs",
                {tx_byte, tx_start, bus_req, bus_addr, bus_wdata, bus_we, busy, err_overrun}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single write with grant tied high.
    gntTie = 1'b1;
    applyStimulus(0, 16'hF000, 16'h1234, 0);
    waitIdle("t1");
    checkOutput("t1_write_count", wrLog.size(), 1);
    checkOutput("t1_write", wrLog[$], 32'hF000_1234);
    checkOutput("t1_ack", txLog[$], 8'h4B);

    // Write then read back the same location.
    applyStimulus(0, 16'h0010, 16'hBEEF, 1);
    waitIdle("t2w");
    applyStimulus(1, 16'h0010, 16'h0000, 2);
    waitIdle("t2r");
    checkOutput("t2_reply_hi", txLog[txLog.size() - 2], 8'hBE);
    checkOutput("t2_reply_lo", txLog[$], 8'hEF);

    // Read the switch register with a 20-cycle grant delay.
    gntTie = 1'b0;
    gntDelay = 20;
    applyStimulus(1, 16'hF004, 16'h0000, 0);
    reqNoGnt = 0;
    addrEarly = 0;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      if (bus_req && !bus_gnt) begin
        reqNoGnt++;
        if (bus_addr != 16'h0000) addrEarly++;
      end
      n++;
    end
    checkOutput("t3_req_wait", reqNoGnt, 20);
    checkOutput("t3_no_early_addr", addrEarly, 0);
    checkOutput("t3_reply", {txLog[txLog.size() - 2], txLog[$]}, 16'hA5A5);
    waitIdle("t3");

    // Unknown command byte, then a normal write.
    gntTie = 1'b1;
    applyStimulus(2, 16'h0000, 16'h0041, 0);
    waitIdle("t4");
    checkOutput("t4_busy", busy, 0);
    checkOutput("t4_reply", txLog[$], 8'h3F);
    applyStimulus(0, 16'h0030, 16'hCAFE, 0);
    waitIdle("t4w");
    checkOutput("t4_ack", txLog[$], 8'h4B);

    // Abandoned frame times out silently.
    nLog = txLog.size();
    nWr  = wrLog.size();
    sendByte(8'h57, 0);
    sendByte(8'h00, 0);
    sendByte(8'h20, 0);
    @(negedge clk);
    checkOutput("t5_busy_in_frame", busy, 1);
    repeat (150) @(negedge clk);
    checkOutput("t5_aborted", busy, 0);
    checkOutput("t5_no_reply", txLog.size(), nLog);
    checkOutput("t5_no_write", wrLog.size(), nWr);
    applyStimulus(0, 16'h0040, 16'h1111, 60);
    waitIdle("t5slow");
    checkOutput("t5_slow_write", wrLog[$], 32'h0040_1111);

    // Randomized frames, gaps, grant delays and transmitter speeds.
    for (int i = 0; i < 30; i++) begin
      gntTie   = ($urandom_range(0, 1) == 1);
      gntDelay = $urandom_range(0, 6);
      txDelay  = $urandom_range(2, 8);
      kind     = $urandom_range(0, 9);
      if (kind < 4) begin
        applyStimulus(0, pool[$urandom_range(0, 5)], 16'($urandom), $urandom_range(0, 4));
      end else if (kind < 8) begin
        applyStimulus(1, pool[$urandom_range(0, 5)], 16'h0000, $urandom_range(0, 4));
      end else begin
        bad = 8'($urandom);
        while (bad == 8'h57 || bad == 8'h52) bad = 8'($urandom);
        applyStimulus(2, 16'h0000, {8'h00, bad}, $urandom_range(0, 4));
      end
      waitIdle("rand");
    end
    checkOutput("rand_no_overrun", err_overrun, 0);

    // Byte arriving during TX_WAIT is dropped and flags overrun.
    gntTie = 1'b1;
    txDelay = 8;
    applyStimulus(1, 16'h0100, 16'h0000, 0);
    n = 0;
    while (!tx_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) flagFail("t6_tx_start_timeout");
    sendByte(8'h11, 0);
    #2 checkOutput("t6_overrun_set", err_overrun, 1);
    waitIdle("t6");
    applyStimulus(0, 16'h0050, 16'h2222, 0);
    waitIdle("t6w");
    checkOutput("t6_overrun_sticky", err_overrun, 1);

    // Reset while waiting for the bus clears every output at once.
    gntTie = 1'b0;
    gntDelay = 1000;
    sendByte(8'h52, 0);
    sendByte(8'h00, 0);
    sendByte(8'h10, 0);
    repeat (5) @(negedge clk);
    checkOutput("t6_in_req", {busy, bus_req}, 2'b11);
    #2 rst_n = 1'b0;
    #1 checkOutput("t6_reset_outputs",
                   {tx_byte, tx_start, bus_req, bus_addr, bus_wdata, bus_we, busy, err_overrun}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    gntTie = 1'b1;
    txDelay = 3;
    applyStimulus(1, 16'h0010, 16'h0000, 0);
    waitIdle("t6post");
    checkOutput("t6_post_overrun", err_overrun, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
